// File: rtl/adc_cap_fifo.sv
// rtl/adc_cap_fifo.sv - armed capture FIFO for the serialized ADC sample stream
//
// Records cap_len samples from the ADC_DATA/ADC_DATA_VALID stream once started.
// The samples go into a 2^AW-entry FIFO that the readout drains over a valid/ready handshake.
// Optional feature macro: ADC_CAP_DROP_CNT_EN adds a saturating 16-bit drop_cnt output.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ADC_DATA[DW]          sample from packet control
//   ADC_DATA_VALID        one-cycle sample qualifier, no backpressure
//   cap_start, cap_abort  start pulse / abort+flush (abort wins)
//   cap_len[16]           samples to capture, latched on accepted start
//   rd_data, rd_valid     show-ahead FIFO head / not-empty
//   rd_ready              readout pop request
//   cap_busy, cap_done    capturing / capture complete
//   cap_ovf               sticky: a captured sample was dropped
//   fill_level[AW+1]      FIFO occupancy 0..2^AW
//   drop_cnt[16]          dropped sample count (ADC_CAP_DROP_CNT_EN only)

module adc_cap_fifo #(
  parameter int DW = 18,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] ADC_DATA,
  input  logic          ADC_DATA_VALID,
  input  logic          cap_start,
  input  logic          cap_abort,
  input  logic [15:0]   cap_len,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          cap_busy,
  output logic          cap_done,
  output logic          cap_ovf,
  output logic [AW:0]   fill_level
`ifdef ADC_CAP_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, CAPT, DONE} state_t;

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   FILL_ONE = 1;

  state_t          state, state_nxt;
  logic [DW-1:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [15:0]     len_q, cnt;
  logic            start_ok, capture, last, full, push, pop, drop;

  always_comb begin
    // A start is only honoured outside CAPT; abort overrides it.
    start_ok = cap_start && !cap_abort && (state != CAPT);
    // A zero-length capture never takes any sample.
    capture  = (state == CAPT) && ADC_DATA_VALID && (len_q != 16'd0);
    last     = capture && (cnt == len_q - 16'd1);
    // Occupancy of exactly 2^AW is the only value with the MSB set.
    full     = fill_level[AW];
    pop      = rd_valid && rd_ready;
    // When full, a same-cycle pop frees the slot the new sample needs.
    push     = capture && (!full || pop);
    drop     = capture && !push;
  end

  always_comb begin
    state_nxt = state;
    if (cap_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok) state_nxt = CAPT;
        CAPT:    if ((len_q == 16'd0) || last) state_nxt = DONE;
        DONE:    if (start_ok) state_nxt = CAPT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      cap_ovf    <= 1'b0;
      len_q      <= 16'd0;
      cnt        <= 16'd0;
    end else if (cap_abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      cap_ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fill_level <= fill_level + FILL_ONE;
        2'b01:   fill_level <= fill_level - FILL_ONE;
        default: fill_level <= fill_level;
      endcase
      if (start_ok) begin
        len_q   <= cap_len;
        cnt     <= 16'd0;
        cap_ovf <= 1'b0;
      end else begin
        // Dropped samples still count toward the capture length.
        if (capture) cnt <= cnt + 16'd1;
        if (drop)    cap_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !cap_abort) mem[wr_ptr] <= ADC_DATA;
  end

`ifdef ADC_CAP_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || cap_abort || start_ok) drop_cnt <= 16'd0;
    else if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

  assign rd_data  = mem[rd_ptr];
  assign rd_valid = (fill_level != '0);
  assign cap_busy = (state == CAPT);
  assign cap_done = (state == DONE);

endmodule

// File: tb/tb_adc_cap_fifo.sv
// tb/tb_adc_cap_fifo.sv - self-checking bench for adc_cap_fifo with a queue-based reference model

module tb_adc_cap_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] ADC_DATA;
  logic        ADC_DATA_VALID;
  logic        cap_start, cap_abort;
  logic [15:0] cap_len;
  logic [17:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        cap_busy, cap_done, cap_ovf;
  logic [6:0]  fill_level;
`ifdef ADC_CAP_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  adc_cap_fifo #(.DW(18), .AW(6)) dut (
    .clk(clk), .rst_n(rst_n), .ADC_DATA(ADC_DATA), .ADC_DATA_VALID(ADC_DATA_VALID),
    .cap_start(cap_start), .cap_abort(cap_abort), .cap_len(cap_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .cap_busy(cap_busy), .cap_done(cap_done), .cap_ovf(cap_ovf), .fill_level(fill_level)
`ifdef ADC_CAP_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state 0=idle 1=capturing 2=done; FIFO as a queue.
  int          m_state, m_len, m_cnt, m_drop;
  bit          m_ovf;
  logic [17:0] m_q[$];

  typedef struct {
    logic        st, ab;
    logic [15:0] len;
    logic        v;
    logic [17:0] d;
    logic        rdy;
    logic        e_busy, e_done;
    logic [6:0]  e_fill;
    logic        e_rv;
    logic [17:0] e_head;
  } vec_t;
  vec_t tbl[11];

  function automatic vec_t mk(input logic st, input logic ab, input logic [15:0] len,
                              input logic v, input logic [17:0] d, input logic rdy,
                              input logic eb, input logic ed, input logic [6:0] ef,
                              input logic erv, input logic [17:0] eh);
    vec_t r;
    r.st = st; r.ab = ab; r.len = len; r.v = v; r.d = d; r.rdy = rdy;
    r.e_busy = eb; r.e_done = ed; r.e_fill = ef; r.e_rv = erv; r.e_head = eh;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop, cap, push;
    if (cap_abort) begin
      m_q.delete();
      m_state = 0; m_ovf = 0; m_drop = 0;
    end else begin
      pop  = (m_q.size() > 0) && rd_ready;
      cap  = (m_state == 1) && ADC_DATA_VALID && (m_len != 0);
      push = cap && ((m_q.size() < 64) || pop);
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(ADC_DATA);
      if (cap && !push) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
      if ((m_state != 1) && cap_start) begin
        m_state = 1; m_len = int'(cap_len); m_cnt = 0; m_ovf = 0; m_drop = 0;
      end else if (m_state == 1) begin
        if (m_len == 0) m_state = 2;
        else if (ADC_DATA_VALID) begin
          m_cnt++;
          if (m_cnt == m_len) m_state = 2;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("busy", 32'(cap_busy), 32'(m_state == 1));
    check("done", 32'(cap_done), 32'(m_state == 2));
    check("ovf", 32'(cap_ovf), 32'(m_ovf));
    check("fill_level", 32'(fill_level), 32'(m_q.size()));
    check("rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("rd_data", 32'(rd_data), 32'(m_q[0]));
`ifdef ADC_CAP_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // Called just after a falling edge; drives inputs, steps the model, then checks after the next rising edge.
  task automatic cycle(input logic st, input logic ab, input logic [15:0] len,
                       input logic v, input logic [17:0] d, input logic rdy);
    cap_start = st; cap_abort = ab; cap_len = len;
    ADC_DATA_VALID = v; ADC_DATA = d; rd_ready = rdy;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cap_start = 1'b1; cap_abort = 1'b0; cap_len = 16'd4;
    ADC_DATA_VALID = 1'b1; ADC_DATA = 18'h2AAAA; rd_ready = 1'b1;
    m_q.delete();
    m_state = 0; m_ovf = 0; m_drop = 0; m_len = 0; m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    int budget;
    int bias;
    rst_n = 1'b0;
    cap_start = 1'b0; cap_abort = 1'b0; cap_len = 16'd0;
    ADC_DATA_VALID = 1'b0; ADC_DATA = 18'd0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Directed table: ignored mid-capture start, zero length, abort beating start.
    tbl[0]  = mk(1'b0, 1'b0, 16'd0, 1'b0, 18'h0,  1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 18'h0);
    tbl[1]  = mk(1'b1, 1'b0, 16'd3, 1'b0, 18'h0,  1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 18'h0);
    tbl[2]  = mk(1'b0, 1'b0, 16'd0, 1'b1, 18'h11, 1'b0, 1'b1, 1'b0, 7'd1, 1'b1, 18'h11);
    tbl[3]  = mk(1'b1, 1'b0, 16'd9, 1'b1, 18'h22, 1'b0, 1'b1, 1'b0, 7'd2, 1'b1, 18'h11);
    tbl[4]  = mk(1'b0, 1'b0, 16'd0, 1'b0, 18'h0,  1'b0, 1'b1, 1'b0, 7'd2, 1'b1, 18'h11);
    tbl[5]  = mk(1'b0, 1'b0, 16'd0, 1'b1, 18'h33, 1'b0, 1'b0, 1'b1, 7'd3, 1'b1, 18'h11);
    tbl[6]  = mk(1'b0, 1'b0, 16'd0, 1'b1, 18'h44, 1'b0, 1'b0, 1'b1, 7'd3, 1'b1, 18'h11);
    tbl[7]  = mk(1'b0, 1'b0, 16'd0, 1'b0, 18'h0,  1'b1, 1'b0, 1'b1, 7'd2, 1'b1, 18'h22);
    tbl[8]  = mk(1'b1, 1'b0, 16'd0, 1'b0, 18'h0,  1'b0, 1'b1, 1'b0, 7'd2, 1'b1, 18'h22);
    tbl[9]  = mk(1'b0, 1'b0, 16'd0, 1'b1, 18'h55, 1'b0, 1'b0, 1'b1, 7'd2, 1'b1, 18'h22);
    tbl[10] = mk(1'b1, 1'b1, 16'd5, 1'b0, 18'h0,  1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 18'h0);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].st, tbl[i].ab, tbl[i].len, tbl[i].v, tbl[i].d, tbl[i].rdy);
      check($sformatf("tbl%0d_busy", i), 32'(cap_busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_done", i), 32'(cap_done), 32'(tbl[i].e_done));
      check($sformatf("tbl%0d_fill", i), 32'(fill_level), 32'(tbl[i].e_fill));
      check($sformatf("tbl%0d_rv", i), 32'(rd_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) check($sformatf("tbl%0d_head", i), 32'(rd_data), 32'(tbl[i].e_head));
    end

    // Basic capture of 8 samples with continuous reads.
    cycle(1'b1, 1'b0, 16'd8, 1'b0, 18'h0, 1'b1);
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b0, 16'd0, 1'b1, 18'(i), 1'b1);
    check("basic_done", 32'(cap_done), 32'd1);
    check("basic_ovf", 32'(cap_ovf), 32'd0);
    repeat (3) cycle(1'b0, 1'b0, 16'd0, 1'b0, 18'h0, 1'b1);
    check("basic_fill", 32'(fill_level), 32'd0);

    // Overflow: 80 samples into 64 entries with no reads.
    cycle(1'b1, 1'b0, 16'd80, 1'b0, 18'h0, 1'b0);
    for (int i = 1; i <= 80; i++) cycle(1'b0, 1'b0, 16'd0, 1'b1, 18'(i), 1'b0);
    check("ovf_fill", 32'(fill_level), 32'd64);
    check("ovf_flag", 32'(cap_ovf), 32'd1);
    check("ovf_done", 32'(cap_done), 32'd1);
`ifdef ADC_CAP_DROP_CNT_EN
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd16);
`endif
    for (int i = 1; i <= 64; i++) begin
      check("drain_order", 32'(rd_data), 32'(i));
      cycle(1'b0, 1'b0, 16'd0, 1'b0, 18'h0, 1'b1);
    end
    check("drain_empty", 32'(fill_level), 32'd0);

    // Full FIFO with a sample arriving alongside a pop.
    cycle(1'b1, 1'b0, 16'd70, 1'b0, 18'h0, 1'b0);
    for (int i = 0; i < 64; i++) cycle(1'b0, 1'b0, 16'd0, 1'b1, 18'(12'h100 + i), 1'b0);
    cycle(1'b0, 1'b0, 16'd0, 1'b1, 18'h3FFFF, 1'b1);
    check("fullpop_fill", 32'(fill_level), 32'd64);
    check("fullpop_ovf", 32'(cap_ovf), 32'd0);
    check("fullpop_head", 32'(rd_data), 32'h101);

    // Abort with 10 entries buffered.
    cycle(1'b1, 1'b1, 16'd0, 1'b0, 18'h0, 1'b0);
    cycle(1'b1, 1'b0, 16'd20, 1'b0, 18'h0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'd0, 1'b1, 18'(i + 7), 1'b0);
    check("pre_abort_fill", 32'(fill_level), 32'd10);
    cycle(1'b0, 1'b1, 16'd0, 1'b1, 18'h1234, 1'b0);
    check("abort_fill", 32'(fill_level), 32'd0);
    check("abort_rv", 32'(rd_valid), 32'd0);
    check("abort_idle", 32'({cap_busy, cap_done}), 32'd0);

    // 200-sample capture with gaps and continuous reads: pointers wrap.
    cycle(1'b1, 1'b0, 16'd200, 1'b0, 18'h0, 1'b1);
    budget = 0;
    while (m_state == 1 && budget < 2000) begin
      cycle(1'b0, 1'b0, 16'd0, 1'b1 & (($urandom % 4) != 0), 18'($urandom), 1'b1);
      budget++;
    end
    check("wrap_done", 32'(cap_done), 32'd1);

    // Reset in the middle of a capture with 5 entries buffered.
    cycle(1'b1, 1'b0, 16'd20, 1'b0, 18'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'd0, 1'b1, 18'(i + 40), 1'b0);
    do_reset();
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_flags", 32'({rd_valid, cap_busy, cap_done, cap_ovf}), 32'd0);

    // Randomized traffic with alternating read pressure.
    bias = 90;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) bias = (bias == 90) ? 10 : 90;
      cycle(1'(($urandom % 40) == 0), 1'(($urandom % 200) == 0), 16'($urandom_range(0, 99)),
            1'(($urandom % 3) != 0), 18'($urandom), 1'(($urandom % 100) < bias));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
